// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding and wait-counter width.
// Wait states are compiled in only when MEM_WAIT_STATES_EN is defined.
package mem_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bram.sv
// DEPTH_WORDS x 32 synchronous RAM with four byte-lane write enables and a registered,
// read-before-write output port. Contents are never reset.
module mem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_rd_reg;

      // Read and write in the same edge: the output register captures the old byte.
      always_ff @(posedge clk) begin
        if (en) begin
          lane_rd_reg <= lane_mem[addr];
        end
        if (we[gi]) begin
          lane_mem[addr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder for a valid/ready initiator bus, one access at a time.
// Define MEM_WAIT_STATES_EN to insert WAIT_CYCLES wait states before each response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam int                    IDX_W         = $clog2(DEPTH_WORDS);
  localparam logic [29:0]           DEPTH_LIMIT   = 30'(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  state_t             state_reg;
  logic               ready_reg;
  logic               error_reg;
  logic               rdata_zero_reg;

  logic               req_in_range;
  logic [IDX_W-1:0]   req_idx;

  logic               commit_next;
  logic               commit_in_range;
  logic [IDX_W-1:0]   commit_idx;
  logic [31:0]        commit_wdata;
  logic [3:0]         commit_wstrb;

  logic               bram_en;
  logic [3:0]         bram_we;
  logic [31:0]        bram_rdata;

  logic               unused_ok;

  // Out-of-range addresses must not alias onto low words, so the full word address is compared.
  assign req_in_range = (mem_addr[31:2] < DEPTH_LIMIT);
  assign req_idx      = mem_addr[IDX_W+1:2];

`ifdef MEM_WAIT_STATES_EN
  logic [WAIT_CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  in_range_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  wait_done;

  assign wait_done = (state_reg == WAIT) && (cnt_reg == WAIT_CNT_W'(1));

  always_comb begin
    commit_next     = 1'b0;
    commit_in_range = req_in_range;
    commit_idx      = req_idx;
    commit_wdata    = mem_wdata;
    commit_wstrb    = mem_wstrb;
    if (wait_done) begin
      commit_next     = !reset;
      commit_in_range = in_range_reg;
      commit_idx      = idx_reg;
      commit_wdata    = wdata_reg;
      commit_wstrb    = wstrb_reg;
    end else if ((state_reg == IDLE) && mem_valid && (WAIT_CNT_INIT == '0)) begin
      commit_next = !reset;
    end
  end
`else
  always_comb begin
    commit_next     = (state_reg == IDLE) && mem_valid && !reset;
    commit_in_range = req_in_range;
    commit_idx      = req_idx;
    commit_wdata    = mem_wdata;
    commit_wstrb    = mem_wstrb;
  end
`endif

  assign bram_en = commit_next && commit_in_range;
  assign bram_we = bram_en ? commit_wstrb : 4'b0000;

  mem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (IDX_W)
  ) u_bram (
    .clk   (clk),
    .en    (bram_en),
    .we    (bram_we),
    .addr  (commit_idx),
    .wdata (commit_wdata),
    .rdata (bram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ready_reg      <= 1'b0;
      error_reg      <= 1'b0;
      rdata_zero_reg <= 1'b1;
`ifdef MEM_WAIT_STATES_EN
      cnt_reg        <= '0;
`endif
    end else begin
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      // The commit edge is the edge entering RESPOND; outputs register alongside the RAM read.
      if (commit_next) begin
        ready_reg      <= 1'b1;
        error_reg      <= !commit_in_range;
        rdata_zero_reg <= !commit_in_range;
      end
      case (state_reg)
        IDLE: begin
          if (mem_valid) begin
`ifdef MEM_WAIT_STATES_EN
            idx_reg      <= req_idx;
            in_range_reg <= req_in_range;
            wdata_reg    <= mem_wdata;
            wstrb_reg    <= mem_wstrb;
            if (WAIT_CNT_INIT != '0) begin
              state_reg <= WAIT;
              cnt_reg   <= WAIT_CNT_INIT;
            end else begin
              state_reg <= RESPOND;
            end
`else
            state_reg <= RESPOND;
`endif
          end
        end
`ifdef MEM_WAIT_STATES_EN
        WAIT: begin
          if (cnt_reg == WAIT_CNT_W'(1)) begin
            state_reg <= RESPOND;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - WAIT_CNT_W'(1);
          end
        end
`endif
        RESPOND: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_ready = ready_reg;
  assign mem_error = error_reg;
  assign mem_rdata = rdata_zero_reg ? 32'h0 : bram_rdata;

  // mem_instr and the byte offset are deliberately informational only.
  assign unused_ok = &{1'b0, mem_instr, mem_addr[1:0], WAIT_CNT_INIT};

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; works with or without MEM_WAIT_STATES_EN.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;
`ifdef MEM_WAIT_STATES_EN
  localparam int EXP_LAT = 1 + WAITC;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error)
  );

  // Drives one request, drops valid after acceptance and scrambles the inputs,
  // then waits (bounded) for the response. lat=0 means no response arrived.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output logic rdy_next);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = instr;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_addr  = 32'hFFFF_FFFC;
    mem_wdata = 32'h0BAD_0BAD;
    mem_wstrb = 4'b1111;
    mem_instr = 1'b0;
    lat   = 0;
    rdata = 32'hx;
    err   = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        lat   = n;
        rdata = mem_rdata;
        err   = mem_error;
        break;
      end
    end
    @(negedge clk);
    rdy_next  = mem_ready;
    mem_wstrb = 4'b0000;
    $display("access addr=%h wstrb=%b wdata=%h instr=%b -> rdata=%h err=%b lat=%0d",
             addr, wstrb, wdata, instr, rdata, err, lat);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
    n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", mem_error); end
    n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
  endtask

  task automatic test_full_word();
    logic [31:0] rd; logic er; int lat; logic rn;
    do_access(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, rd, er, lat, rn);
    n_checks++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (rn !== 1'b0) begin n_fail++; $display("FAIL write_ready_pulse: ready after pulse got %b want 0", rn); end
    do_access(32'h10, 32'h0, 4'b0000, 1'b0, rd, er, lat, rn);
    n_checks++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL read_error: got %b want 0", er); end
    n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_hold: got %h want deadbeef", mem_rdata); end
    // Write returns the word as it was before the write.
    do_access(32'h10, 32'h0102_0304, 4'b1111, 1'b0, rd, er, lat, rn);
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_prewrite_data: got %h want deadbeef", rd); end
    do_access(32'h10, 32'h0, 4'b0000, 1'b1, rd, er, lat, rn);
    n_checks++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL instr_read_data: got %h want 01020304", rd); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic er; int lat; logic rn;
    do_access(32'h20, 32'h1122_3344, 4'b1111, 1'b0, rd, er, lat, rn);
    do_access(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, er, lat, rn);
    n_checks++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL strobe_prewrite_data: got %h want 11223344", rd); end
    do_access(32'h20, 32'h0, 4'b0000, 1'b0, rd, er, lat, rn);
    n_checks++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_merge: got %h want 11bb33dd", rd); end
    do_access(32'h23, 32'h0, 4'b0000, 1'b0, rd, er, lat, rn);
    n_checks++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL unaligned_read: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; logic rn;
    do_access(32'h0, 32'hCAFE_F00D, 4'b1111, 1'b0, rd, er, lat, rn);
    do_access(32'h1000, 32'h0, 4'b0000, 1'b0, rd, er, lat, rn);
    n_checks++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL oor_latency: got %0d want %0d", lat, EXP_LAT); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_error: got %b want 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rd); end
    n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL oor_error_idle: got %b want 0", mem_error); end
    n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata_hold: got %h want 0", mem_rdata); end
    do_access(32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b0, rd, er, lat, rn);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_write_error: got %b want 1", er); end
    do_access(32'h0, 32'h0, 4'b0000, 1'b0, rd, er, lat, rn);
    n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_no_wrap: word0 got %h want cafef00d", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL inrange_error: got %b want 0", er); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; logic rn; logic seen_ready;
    do_access(32'h8, 32'h1234_5678, 4'b1111, 1'b0, rd, er, lat, rn);
    seen_ready = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h8;
    mem_wdata = 32'h0000_0055;
    mem_wstrb = 4'b1111;
`ifdef MEM_WAIT_STATES_EN
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    @(negedge clk);
    seen_ready = seen_ready | mem_ready;
    reset = 1'b1;
`else
    reset = 1'b1;
`endif
    @(negedge clk);
    seen_ready = seen_ready | mem_ready;
    reset     = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      seen_ready = seen_ready | mem_ready;
    end
    $display("reset during pending write 0x55 to 0x8, ready seen=%b", seen_ready);
    n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b want 0", seen_ready); end
    n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL abort_rdata_reset: got %h want 0", mem_rdata); end
    do_access(32'h8, 32'h0, 4'b0000, 1'b0, rd, er, lat, rn);
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_no_write: got %h want 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; logic rn;
    logic [31:0] data_q [2];
    int pos_q [2];
    int pulses; logic prev_ready; logic double_high;
    do_access(32'h0, 32'hA0A0_A0A0, 4'b1111, 1'b0, rd, er, lat, rn);
    do_access(32'h4, 32'hB1B1_B1B1, 4'b1111, 1'b0, rd, er, lat, rn);
    pulses = 0; prev_ready = 1'b0; double_high = 1'b0;
    data_q[0] = '0; data_q[1] = '0; pos_q[0] = 0; pos_q[1] = 0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    mem_wstrb = 4'b0000;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (mem_ready === 1'b1 && prev_ready === 1'b1) double_high = 1'b1;
      if (mem_ready === 1'b1 && prev_ready !== 1'b1) begin
        if (pulses < 2) begin
          data_q[pulses] = mem_rdata;
          pos_q[pulses]  = n;
        end
        pulses++;
        $display("back-to-back pulse %0d at cycle %0d rdata=%h", pulses, n, mem_rdata);
        if (pulses == 1) mem_addr = 32'h4;
        else mem_valid = 1'b0;
      end
      prev_ready = mem_ready;
    end
    mem_valid = 1'b0;
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 2", pulses); end
    n_checks++; if (double_high !== 1'b0) begin n_fail++; $display("FAIL b2b_single_cycle: ready stayed high, got %b want 0", double_high); end
    n_checks++; if (data_q[0] !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL b2b_data0: got %h want a0a0a0a0", data_q[0]); end
    n_checks++; if (data_q[1] !== 32'hB1B1_B1B1) begin n_fail++; $display("FAIL b2b_data1: got %h want b1b1b1b1", data_q[1]); end
    n_checks++; if (pos_q[0] != EXP_LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", pos_q[0], EXP_LAT); end
    n_checks++; if (pos_q[1] - pos_q[0] != EXP_LAT + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", pos_q[1] - pos_q[0], EXP_LAT + 1); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_strobe();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
